// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared RV32 definitions for the execute-stage M-extension
//                unit: data width, funct3 op encodings, FSM state encoding,
//                fixed results for divide-by-zero and signed overflow, and
//                per-op operand signedness helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int XLEN         = 32;
    localparam int MULDIV_ITERS = 32;

    // M-extension funct3 encodings
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    // Multiply/divide sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_e;

    // Architecturally fixed results for the corner cases of division
    localparam logic [XLEN-1:0] DIV_ZERO_QUOT = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] OVF_QUOT      = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] OVF_REM       = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] INT_MIN       = {1'b1, {(XLEN-1){1'b0}}};

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM
    function automatic logic rs1_is_signed(input muldiv_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV)  || (op == OP_REM);
    endfunction

    // rs2 is treated as signed for MULH, DIV and REM
    function automatic logic rs2_is_signed(input muldiv_op_e op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_restoring_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_restoring_step
//  Description : One combinational iteration of an unsigned restoring divide.
//                Shifts the next dividend bit into the partial remainder,
//                trial-subtracts the divisor and restores on underflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_restoring_step #(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic [XLEN:0]   rem_i,
    input  logic            dividend_bit_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN:0]   rem_o,
    output logic            qbit_o
);

    logic [XLEN+1:0] shifted;

    // Shift, trial subtract, keep the difference only when it does not underflow.
    // When the trial succeeds the difference is below the divisor, so it fits
    // the XLEN+1 bit remainder without its top bit.
    always_comb begin
        shifted = {rem_i, dividend_bit_i};
        qbit_o  = (shifted >= {2'b00, divisor_i});
        rem_o   = qbit_o ? (shifted[XLEN:0] - {1'b0, divisor_i}) : shifted[XLEN:0];
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative RV32M multiply/divide unit for the execute stage.
//                Radix-2 shift-add multiply and restoring divide, both on
//                operand magnitudes with a final sign fix-up. Produces a
//                one-cycle write-back request (done/we_out/rd_out/result).
//                Build option: MULDIV_FAST_MUL_EN - MUL-class ops use a
//                single-cycle multiplier instead of the shift-add loop.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            we_out
);
    import riscv_pkg::*;

    localparam int         CNT_W     = 6;
    localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(MULDIV_ITERS);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    muldiv_state_e     state_q;
    muldiv_op_e        op_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              sign_a_q;
    logic              sign_b_q;
    logic [XLEN-1:0]   mag_a_q;
    logic [XLEN-1:0]   mag_b_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN:0]     rem_q;
    logic              special_q;
    logic [XLEN-1:0]   special_res_q;
    logic              busy_q;
    logic              done_q;
    logic              we_q;
    logic [XLEN-1:0]   result_q;
    logic [4:0]        rd_q;

    // ------------------------------------------------------------------
    // Accept-time operand conditioning
    // ------------------------------------------------------------------
    muldiv_op_e      op_in;
    logic            neg_a_d;
    logic            neg_b_d;
    logic [XLEN-1:0] mag_a_d;
    logic [XLEN-1:0] mag_b_d;
    logic            div_zero_d;
    logic            div_ovf_d;
    logic            special_d;
    logic [XLEN-1:0] special_res_d;

    // Sign extraction, magnitudes and early-out detection for a new request
    always_comb begin
        op_in      = muldiv_op_e'(funct3);
        neg_a_d    = rs1_is_signed(op_in) & rs1_val[XLEN-1];
        neg_b_d    = rs2_is_signed(op_in) & rs2_val[XLEN-1];
        mag_a_d    = neg_a_d ? -rs1_val : rs1_val;
        mag_b_d    = neg_b_d ? -rs2_val : rs2_val;
        div_zero_d = funct3[2] & (rs2_val == '0);
        div_ovf_d  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                     (rs1_val == INT_MIN) && (rs2_val == {XLEN{1'b1}});
        special_d  = div_zero_d | div_ovf_d;
        // funct3[1] distinguishes REM/REMU from DIV/DIVU
        if (div_zero_d) begin
            special_res_d = funct3[1] ? rs1_val : DIV_ZERO_QUOT;
        end else begin
            special_res_d = funct3[1] ? OVF_REM : OVF_QUOT;
        end
    end

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    logic [XLEN-1:0]   mul_addend;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_acc_d;
    logic [XLEN:0]     div_rem_d;
    logic              div_qbit;
    logic [XLEN-1:0]   quot_d;
    logic [2*XLEN-1:0] prod_d;
    logic [XLEN-1:0]   final_res_d;

    // One restoring-divide step, reused on every DIV cycle
    div_restoring_step #(
        .XLEN           (XLEN)
    ) u_div_step (
        .rem_i          (rem_q),
        .dividend_bit_i (acc_q[XLEN-1]),
        .divisor_i      (mag_b_q),
        .rem_o          (div_rem_d),
        .qbit_o         (div_qbit)
    );

    // Shift-add step, quotient shift, and final sign-corrected result selection.
    // Multiply keeps the multiplier in the low half of the accumulator and
    // retires one bit per cycle as the product grows in from the top.
    // Divide feeds dividend bits out of the low half MSB-first and shifts
    // quotient bits in behind them.
    always_comb begin
        mul_addend = acc_q[0] ? mag_a_q : '0;
        mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mul_addend};
        mul_acc_d  = {mul_sum, acc_q[XLEN-1:1]};
        quot_d     = {acc_q[XLEN-2:0], div_qbit};
        prod_d     = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;

        if (special_q) begin
            final_res_d = special_res_q;
        end else if (!op_q[2]) begin
            final_res_d = (op_q == OP_MUL) ? prod_d[XLEN-1:0] : prod_d[2*XLEN-1:XLEN];
        end else if (!op_q[1]) begin
            final_res_d = (sign_a_q ^ sign_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        end else begin
            final_res_d = sign_a_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Sequencer: accept, iterate, finalize, write-back pulse
    // ------------------------------------------------------------------
    // Single FSM register block; all outputs come straight from flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            op_q          <= OP_MUL;
            cnt_q         <= '0;
            sign_a_q      <= 1'b0;
            sign_b_q      <= 1'b0;
            mag_a_q       <= '0;
            mag_b_q       <= '0;
            acc_q         <= '0;
            rem_q         <= '0;
            special_q     <= 1'b0;
            special_res_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            we_q          <= 1'b0;
            result_q      <= '0;
            rd_q          <= '0;
        end else if (kill && (state_q != ST_IDLE)) begin
            // Flush: drop the operation, suppress any write-back, keep result
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    we_q   <= 1'b0;
                    if (start && !kill) begin
                        op_q          <= op_in;
                        rd_q          <= rd_in;
                        sign_a_q      <= neg_a_d;
                        sign_b_q      <= neg_b_d;
                        mag_a_q       <= mag_a_d;
                        mag_b_q       <= mag_b_d;
                        rem_q         <= '0;
                        special_q     <= special_d;
                        special_res_q <= special_res_d;
                        busy_q        <= 1'b1;
                        // Early-out cases jump the counter to the finalize slot
                        cnt_q         <= special_d ? ITER_LAST : '0;
                        acc_q         <= funct3[2] ? {{XLEN{1'b0}}, mag_a_d}
                                                   : {{XLEN{1'b0}}, mag_b_d};
                        state_q       <= funct3[2] ? ST_DIV : ST_MUL;
`ifdef MULDIV_FAST_MUL_EN
                        // Whole magnitude product in one cycle; sign fix-up
                        // still happens in the finalize slot
                        if (!funct3[2]) begin
                            acc_q <= {{XLEN{1'b0}}, mag_a_d} * {{XLEN{1'b0}}, mag_b_d};
                            cnt_q <= ITER_LAST;
                        end
`endif
                    end
                end

                ST_MUL, ST_DIV: begin
                    if (cnt_q == ITER_LAST) begin
                        result_q <= final_res_d;
                        done_q   <= 1'b1;
                        we_q     <= (rd_q != 5'd0);
                        state_q  <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                        if (state_q == ST_MUL) begin
                            acc_q <= mul_acc_d;
                        end else begin
                            rem_q           <= div_rem_d;
                            acc_q[XLEN-1:0] <= quot_d;
                        end
                    end
                end

                ST_DONE: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    we_q    <= 1'b0;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign we_out = we_q;
    assign result = result_q;
    assign rd_out = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Self-checking bench for muldiv_unit. Expected write-back
//                records are queued when a request is issued and compared
//                when the unit raises done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] rs1_val = 32'd0;
    logic [31:0] rs2_val = 32'd0;
    logic [4:0]  rd_in = 5'd0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        we_out;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    typedef struct packed {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] e;
        logic [7:0]  lat;
    } op_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   acc_cyc  = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .kill    (kill),
        .funct3  (funct3),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .rd_in   (rd_in),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .rd_out  (rd_out),
        .we_out  (we_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference behaviour of the RV32M ops
    function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
        logic signed [63:0] x;
        logic signed [63:0] y;
        logic signed [63:0] p;
        logic               ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'b000: begin x = {32'd0, a}; y = {32'd0, b}; p = x * y; return p[31:0]; end
            3'b001: begin x = {{32{a[31]}}, a}; y = {{32{b[31]}}, b}; p = x * y; return p[63:32]; end
            3'b010: begin x = {{32{a[31]}}, a}; y = {32'd0, b}; p = x * y; return p[63:32]; end
            3'b011: begin x = {32'd0, a}; y = {32'd0, b}; p = x * y; return p[63:32]; end
            3'b100: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Drive one request, return just after its accepting edge
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] e, input bit push);
        @(negedge clk);
        start   = 1'b1;
        funct3  = f;
        rs1_val = a;
        rs2_val = b;
        rd_in   = rd;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        start   = 1'b0;
        funct3  = ~f;
        rs1_val = ~a;
        rs2_val = ~b;
        rd_in   = ~rd;
        if (push) exp_q.push_back('{res: e, rd: rd, we: (rd != 5'd0)});
    endtask

    // Wait (bounded) for done; lat counts edges from the accepting edge
    task automatic wait_done(input int max_cyc, output int lat, output bit ok);
        ok  = 1'b0;
        lat = 0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok  = 1'b1;
                lat = cyc - acc_cyc;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        funct3 = 3'b100;
        rs1_val = 32'd50;
        rs2_val = 32'd0;
        rd_in = 5'd9;
        repeat (3) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (we_out !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", we_out); end
        n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result got %h want 0", result); end
        n_checks++; if (rd_out !== 5'd0) begin n_fail++; $display("FAIL reset_rd got %0d want 0", rd_out); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle busy got %b want 0", busy); end
    endtask

    task automatic test_mul();
        op_t tbl[4];
        tbl[0] = '{f: 3'b000, a: 32'd7,         b: 32'hFFFF_FFFD, rd: 5'd5, e: 32'hFFFF_FFEB, lat: 8'd33};
        tbl[1] = '{f: 3'b001, a: 32'h8000_0000, b: 32'h8000_0000, rd: 5'd3, e: 32'h4000_0000, lat: 8'd33};
        tbl[2] = '{f: 3'b010, a: 32'h8000_0000, b: 32'h8000_0000, rd: 5'd7, e: 32'hC000_0000, lat: 8'd33};
        tbl[3] = '{f: 3'b011, a: 32'h8000_0000, b: 32'h8000_0000, rd: 5'd9, e: 32'h4000_0000, lat: 8'd33};
        foreach (tbl[i]) begin
            exp_t ex;
            int   lat;
            bit   ok;
            issue(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].e, 1'b1);
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mul%0d_busy_after_accept got %b want 1", i, busy); end
            wait_done(60, lat, ok);
            ex = exp_q.pop_front();
            n_checks++;
            if (!ok) begin
                n_fail++; $display("FAIL mul%0d_timeout no done within 60 cycles, want result %h", i, ex.res);
            end else begin
                if (lat != int'(tbl[i].lat)) begin n_fail++; $display("FAIL mul%0d_latency got %0d want %0d", i, lat, tbl[i].lat); end
                n_checks++; if (result !== ex.res) begin n_fail++; $display("FAIL mul%0d_result got %h want %h", i, result, ex.res); end
                n_checks++; if (rd_out !== ex.rd) begin n_fail++; $display("FAIL mul%0d_rd got %0d want %0d", i, rd_out, ex.rd); end
                n_checks++; if (we_out !== ex.we) begin n_fail++; $display("FAIL mul%0d_we got %b want %b", i, we_out, ex.we); end
                n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mul%0d_busy_in_done got %b want 1", i, busy); end
                @(negedge clk);
                n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mul%0d_after_done done=%b busy=%b want 0 0", i, done, busy); end
                n_checks++; if (result !== ex.res) begin n_fail++; $display("FAIL mul%0d_result_hold got %h want %h", i, result, ex.res); end
            end
        end
    endtask

    task automatic test_div();
        op_t tbl[7];
        tbl[0] = '{f: 3'b101, a: 32'd100,        b: 32'd0,         rd: 5'd1, e: 32'hFFFF_FFFF, lat: 8'd1};
        tbl[1] = '{f: 3'b110, a: 32'd100,        b: 32'd0,         rd: 5'd2, e: 32'd100,       lat: 8'd1};
        tbl[2] = '{f: 3'b100, a: 32'h8000_0000,  b: 32'hFFFF_FFFF, rd: 5'd3, e: 32'h8000_0000, lat: 8'd1};
        tbl[3] = '{f: 3'b110, a: 32'h8000_0000,  b: 32'hFFFF_FFFF, rd: 5'd4, e: 32'd0,         lat: 8'd1};
        tbl[4] = '{f: 3'b100, a: 32'hFFFF_FF9C,  b: 32'd7,         rd: 5'd5, e: 32'hFFFF_FFF2, lat: 8'd33};
        tbl[5] = '{f: 3'b110, a: 32'hFFFF_FF9C,  b: 32'd7,         rd: 5'd6, e: 32'hFFFF_FFFE, lat: 8'd33};
        tbl[6] = '{f: 3'b111, a: 32'd100,        b: 32'd7,         rd: 5'd7, e: 32'd2,         lat: 8'd33};
        foreach (tbl[i]) begin
            exp_t ex;
            int   lat;
            bit   ok;
            issue(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].e, 1'b1);
            wait_done(60, lat, ok);
            ex = exp_q.pop_front();
            n_checks++;
            if (!ok) begin
                n_fail++; $display("FAIL div%0d_timeout no done within 60 cycles, want result %h", i, ex.res);
            end else begin
                if (lat != int'(tbl[i].lat)) begin n_fail++; $display("FAIL div%0d_latency got %0d want %0d", i, lat, tbl[i].lat); end
                n_checks++; if (result !== ex.res) begin n_fail++; $display("FAIL div%0d_result got %h want %h", i, result, ex.res); end
                n_checks++; if (we_out !== ex.we || rd_out !== ex.rd) begin n_fail++; $display("FAIL div%0d_wb we=%b rd=%0d want we=%b rd=%0d", i, we_out, rd_out, ex.we, ex.rd); end
            end
        end
    endtask

    task automatic test_rd_zero();
        int lat;
        bit ok;
        issue(3'b000, 32'd3, 32'd4, 5'd0, 32'd12, 1'b1);
        wait_done(60, lat, ok);
        void'(exp_q.pop_front());
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL rd0_timeout no done within 60 cycles");
        end else begin
            if (we_out !== 1'b0) begin n_fail++; $display("FAIL rd0_we got %b want 0", we_out); end
            n_checks++; if (result !== 32'd12) begin n_fail++; $display("FAIL rd0_result got %h want %h", result, 32'd12); end
            n_checks++; if (rd_out !== 5'd0) begin n_fail++; $display("FAIL rd0_rd got %0d want 0", rd_out); end
        end
    endtask

    task automatic test_start_ignored();
        int lat;
        bit ok;
        int pulses;
        issue(3'b000, 32'd12345, 32'd678, 5'd10, 32'd8369910, 1'b1);
        repeat (10) @(negedge clk);
        start = 1'b1; funct3 = 3'b101; rs1_val = 32'd1; rs2_val = 32'd0; rd_in = 5'd20;
        @(negedge clk);
        start = 1'b0;
        wait_done(60, lat, ok);
        void'(exp_q.pop_front());
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL ignore_timeout no done within 60 cycles");
        end else begin
            if (lat != 33) begin n_fail++; $display("FAIL ignore_latency got %0d want 33", lat); end
            n_checks++; if (result !== 32'd8369910) begin n_fail++; $display("FAIL ignore_result got %h want %h", result, 32'd8369910); end
            n_checks++; if (rd_out !== 5'd10) begin n_fail++; $display("FAIL ignore_rd got %0d want 10", rd_out); end
        end
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) pulses++;
        end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL ignore_no_second_op got %0d busy/done cycles want 0", pulses); end
    endtask

    task automatic test_kill();
        int          lat;
        bit          ok;
        int          pulses;
        logic [31:0] prev;
        prev = result;
        issue(3'b101, 32'd1000, 32'd3, 5'd8, 32'd0, 1'b0);
        repeat (10) @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL kill_busy got %b want 0", busy); end
        n_checks++; if (result !== prev) begin n_fail++; $display("FAIL kill_result_hold got %h want %h", result, prev); end
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0 || we_out !== 1'b0) pulses++;
        end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL kill_no_wb got %0d pulses want 0", pulses); end
        issue(3'b101, 32'd1000, 32'd3, 5'd8, 32'd333, 1'b1);
        wait_done(60, lat, ok);
        void'(exp_q.pop_front());
        n_checks++;
        if (!ok || lat != 33) begin n_fail++; $display("FAIL kill_restart_done ok=%b lat=%0d want 1 33", ok, lat); end
        n_checks++; if (result !== 32'd333) begin n_fail++; $display("FAIL kill_restart_result got %h want %h", result, 32'd333); end
    endtask

    task automatic test_rst_mid();
        int lat;
        bit ok;
        int pulses;
        issue(3'b111, 32'd1000, 32'd3, 5'd12, 32'd0, 1'b0);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ctrl busy=%b done=%b want 0 0", busy, done); end
        n_checks++; if (result !== 32'd0 || rd_out !== 5'd0) begin n_fail++; $display("FAIL rst_mid_regs result=%h rd=%0d want 0 0", result, rd_out); end
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0 || we_out !== 1'b0) pulses++;
        end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL rst_mid_no_wb got %0d pulses want 0", pulses); end
        issue(3'b111, 32'd1000, 32'd3, 5'd12, 32'd1, 1'b1);
        wait_done(60, lat, ok);
        void'(exp_q.pop_front());
        n_checks++;
        if (!ok || lat != 33) begin n_fail++; $display("FAIL rst_restart_done ok=%b lat=%0d want 1 33", ok, lat); end
        n_checks++; if (result !== 32'd1 || we_out !== 1'b1) begin n_fail++; $display("FAIL rst_restart_result got %h we=%b want 1 1", result, we_out); end
    endtask

    task automatic test_back_to_back();
        int prev_acc;
        int prev_lat;
        prev_acc = 0;
        prev_lat = 0;
        for (int i = 0; i < 12; i++) begin
            logic [2:0]  f;
            logic [31:0] a;
            logic [31:0] b;
            logic [4:0]  rd;
            int          want_lat;
            int          lat;
            bit          ok;
            exp_t        ex;
            f  = 3'($urandom_range(0, 7));
            a  = $urandom;
            case (i % 4)
                0: b = $urandom;
                1: b = 32'($urandom_range(1, 100));
                2: b = 32'd0;
                default: b = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
            endcase
            rd = 5'($urandom_range(0, 31));
            want_lat = (f[2] && (b == 32'd0 ||
                        (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 33;
            issue(f, a, b, rd, ref_md(f, a, b), 1'b1);
            if (i > 0) begin
                n_checks++;
                if (acc_cyc - prev_acc != prev_lat + 2) begin
                    n_fail++; $display("FAIL b2b%0d_spacing got %0d want %0d", i, acc_cyc - prev_acc, prev_lat + 2);
                end
            end
            wait_done(60, lat, ok);
            ex = exp_q.pop_front();
            n_checks++;
            if (!ok) begin
                n_fail++; $display("FAIL b2b%0d_timeout f=%0d a=%h b=%h want %h", i, f, a, b, ex.res);
            end else begin
                if (lat != want_lat) begin n_fail++; $display("FAIL b2b%0d_latency got %0d want %0d", i, lat, want_lat); end
                n_checks++;
                if (result !== ex.res || rd_out !== ex.rd || we_out !== ex.we) begin
                    n_fail++;
                    $display("FAIL b2b%0d_wb f=%0d a=%h b=%h got %h/%0d/%b want %h/%0d/%b",
                             i, f, a, b, result, rd_out, we_out, ex.res, ex.rd, ex.we);
                end
            end
            prev_acc = acc_cyc;
            prev_lat = want_lat;
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_rd_zero();
        test_start_ignored();
        test_kill();
        test_rst_mid();
        test_back_to_back();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
